// File: rtl/dev_test_fifo_pkg.sv
// Shared constants for the dev test FIFO block: register map, STATUS layout,
// interrupt FSM states.
package dev_test_fifo_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_THRESH = 2'd3;

  localparam int ST_IN_EMPTY  = 16;
  localparam int ST_OUT_FULL  = 17;
  localparam int ST_UNDERFLOW = 18;
  localparam int ST_OVERFLOW  = 19;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_CLR    = 1;

  localparam logic [11:0] STATS_BASE = 12'h800;

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_REQ  = 1'b1
  } irq_state_e;

  // A programmed threshold of zero behaves as one.
  function automatic logic [7:0] eff_thresh(input logic [7:0] t);
    return (t == 8'd0) ? 8'd1 : t;
  endfunction

endpackage

// File: rtl/dev_fifo.sv
// DEPTH x 32 synchronous FIFO. A push on a full FIFO is accepted only when a
// pop completes in the same cycle; callers gate push further if they need to.
module dev_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [31:0]             wdata,
  input  logic                    pop,
  output logic [31:0]             rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dev_test_fifo.sv
// Per-channel testbench<->CPU mailbox FIFOs behind a 32-bit register bus with
// threshold interrupt. Define DEV_TEST_FIFO_STATS_EN for TOTAL_IN/TOTAL_OUT counters.
module dev_test_fifo
  import dev_test_fifo_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bus_req,
  input  logic                      bus_we,
  input  logic [31:0]               bus_addr,
  input  logic [3:0]                bus_be,
  input  logic [31:0]               bus_wdata,
  output logic [31:0]               bus_rdata,
  output logic                      bus_ack,
  input  logic                      int_fin_i,
  output logic                      int_req_o,
  input  logic [CHANNELS-1:0]       tb_in_valid,
  output logic [CHANNELS-1:0]       tb_in_ready,
  input  logic [CHANNELS-1:0][31:0] tb_in_data,
  output logic [CHANNELS-1:0]       tb_out_valid,
  input  logic [CHANNELS-1:0]       tb_out_ready,
  output logic [CHANNELS-1:0][31:0] tb_out_data
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [11:0] a12;
  logic [1:0]  reg_sel;
  logic        reg_hit, rd, wr;
  logic        unused_addr;

  assign a12         = bus_addr[11:0];
  assign reg_sel     = a12[3:2];
  assign reg_hit     = !a12[11] && (int'(a12[10:4]) < CHANNELS);
  assign rd          = bus_req && !bus_we;
  assign wr          = bus_req && bus_we;
  assign unused_addr = ^bus_addr[31:12];

  logic [CHANNELS-1:0]         ch_sel, in_pop, in_push, out_push, ctrl_wr, thr_wr;
  logic [CHANNELS-1:0]         in_full, in_empty, out_full, out_empty, pending;
  logic [CHANNELS-1:0][31:0]   in_head;
  logic [CHANNELS-1:0][CW-1:0] in_cnt, out_cnt;
  logic [CHANNELS-1:0]         unf, ovf, irq_en;
  logic [CHANNELS-1:0][7:0]    thresh;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign ch_sel[c]       = reg_hit && (int'(a12[10:4]) == c);
    assign in_pop[c]       = rd && ch_sel[c] && (reg_sel == REG_DATA);
    assign out_push[c]     = wr && ch_sel[c] && (reg_sel == REG_DATA) && (bus_be == 4'hF);
    assign ctrl_wr[c]      = wr && ch_sel[c] && (reg_sel == REG_CTRL);
    assign thr_wr[c]       = wr && ch_sel[c] && (reg_sel == REG_THRESH);
    // A full input FIFO refuses the testbench even if the CPU pops this cycle.
    assign tb_in_ready[c]  = !in_full[c];
    assign in_push[c]      = tb_in_valid[c] && tb_in_ready[c];
    assign tb_out_valid[c] = !out_empty[c];
    assign pending[c]      = irq_en[c] && (8'(in_cnt[c]) >= eff_thresh(thresh[c]));

    dev_fifo #(.DEPTH(DEPTH)) u_in (
      .clk   (clk),
      .rst   (rst),
      .push  (in_push[c]),
      .wdata (tb_in_data[c]),
      .pop   (in_pop[c]),
      .rdata (in_head[c]),
      .full  (in_full[c]),
      .empty (in_empty[c]),
      .count (in_cnt[c])
    );

    dev_fifo #(.DEPTH(DEPTH)) u_out (
      .clk   (clk),
      .rst   (rst),
      .push  (out_push[c]),
      .wdata (bus_wdata),
      .pop   (tb_out_ready[c]),
      .rdata (tb_out_data[c]),
      .full  (out_full[c]),
      .empty (out_empty[c]),
      .count (out_cnt[c])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unf    <= '0;
      ovf    <= '0;
      irq_en <= '0;
      thresh <= {CHANNELS{8'd1}};
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (in_pop[c] && in_empty[c]) unf[c] <= 1'b1;
        // A full output FIFO only drops the word if the testbench is not draining.
        if (out_push[c] && out_full[c] && !tb_out_ready[c]) ovf[c] <= 1'b1;
        if (ctrl_wr[c]) begin
          irq_en[c] <= bus_wdata[CTRL_IRQ_EN];
          if (bus_wdata[CTRL_CLR]) begin
            unf[c] <= 1'b0;
            ovf[c] <= 1'b0;
          end
        end
        if (thr_wr[c]) thresh[c] <= bus_wdata[7:0];
      end
    end
  end

`ifdef DEV_TEST_FIFO_STATS_EN
  logic [CHANNELS-1:0][31:0] total_in, total_out;
  logic [CHANNELS-1:0]       out_acc;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_acc
    assign out_acc[c] = out_push[c] && (!out_full[c] || tb_out_ready[c]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_in  <= '0;
      total_out <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (in_push[c]) total_in[c]  <= total_in[c] + 32'd1;
        if (out_acc[c]) total_out[c] <= total_out[c] + 32'd1;
      end
    end
  end
`endif

  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_sel[c]) begin
        case (reg_sel)
          REG_DATA:   rd_mux = in_empty[c] ? 32'd0 : in_head[c];
          REG_STATUS: begin
            rd_mux[7:0]          = 8'(in_cnt[c]);
            rd_mux[15:8]         = 8'(out_cnt[c]);
            rd_mux[ST_IN_EMPTY]  = in_empty[c];
            rd_mux[ST_OUT_FULL]  = out_full[c];
            rd_mux[ST_UNDERFLOW] = unf[c];
            rd_mux[ST_OVERFLOW]  = ovf[c];
          end
          REG_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en[c];
          default:    rd_mux[7:0] = thresh[c];
        endcase
      end
`ifdef DEV_TEST_FIFO_STATS_EN
      if (a12[11] && (int'(a12[10:3]) == c))
        rd_mux = a12[2] ? total_out[c] : total_in[c];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ack   <= bus_req;
      bus_rdata <= rd ? rd_mux : 32'd0;
    end
  end

  irq_state_e irq_q, irq_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= IRQ_IDLE;
    else     irq_q <= irq_d;
  end

  // Leaving REQ always passes through IDLE, guaranteeing a low cycle between requests.
  always_comb begin
    irq_d = irq_q;
    case (irq_q)
      IRQ_IDLE: if (|pending) irq_d = IRQ_REQ;
      IRQ_REQ:  if (int_fin_i) irq_d = IRQ_IDLE;
      default:  irq_d = IRQ_IDLE;
    endcase
  end

  assign int_req_o = (irq_q == IRQ_REQ);

endmodule

// File: tb/tb_dev_test_fifo.sv
// Randomized self-checking bench for dev_test_fifo against a queue-based model.
module tb_dev_test_fifo;
  localparam int CH    = 2;
  localparam int DEPTH = 16;

  logic               clk, rst;
  logic               bus_req, bus_we, bus_ack, int_fin_i, int_req_o;
  logic [31:0]        bus_addr, bus_wdata, bus_rdata;
  logic [3:0]         bus_be;
  logic [CH-1:0]      tb_in_valid, tb_in_ready, tb_out_valid, tb_out_ready;
  logic [CH-1:0][31:0] tb_in_data, tb_out_data;

  dev_test_fifo #(.CHANNELS(CH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .int_fin_i(int_fin_i), .int_req_o(int_req_o),
    .tb_in_valid(tb_in_valid), .tb_in_ready(tb_in_ready), .tb_in_data(tb_in_data),
    .tb_out_valid(tb_out_valid), .tb_out_ready(tb_out_ready), .tb_out_data(tb_out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [31:0] in_q [CH][$];
  logic [31:0] out_q [CH][$];
  bit          m_unf [CH], m_ovf [CH], m_irqen [CH];
  logic [7:0]  m_thr [CH];
  logic [31:0] m_tin [CH], m_tout [CH];
  bit          m_irq;

  // Per-step drive
  logic               d_req, d_we, d_fin;
  logic [31:0]        d_addr, d_wdata;
  logic [3:0]         d_be;
  logic [CH-1:0]      d_inv, d_outr;
  logic [CH-1:0][31:0] d_indata;

  task automatic clr_drive();
    d_req = 0; d_we = 0; d_fin = 0; d_addr = 0; d_wdata = 0; d_be = 4'hF;
    d_inv = '0; d_outr = '0; d_indata = '0;
  endtask

  task automatic apply_drive();
    bus_req = d_req; bus_we = d_we; bus_addr = d_addr; bus_wdata = d_wdata; bus_be = d_be;
    tb_in_valid = d_inv; tb_in_data = d_indata; tb_out_ready = d_outr; int_fin_i = d_fin;
  endtask

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      in_q[c].delete(); out_q[c].delete();
      m_unf[c] = 0; m_ovf[c] = 0; m_irqen[c] = 0; m_thr[c] = 8'd1;
      m_tin[c] = 0; m_tout[c] = 0;
    end
    m_irq = 0;
  endtask

  // kind: 0 none, 1 channel register, 2 stats counter
  task automatic decode(input logic [31:0] a, output int kind, output int ch, output int r);
    int a12;
    a12 = int'(a[11:0]);
    kind = 0; ch = 0; r = 0;
    if (a12 < CH * 16) begin
      kind = 1; ch = a12 / 16; r = (a12 % 16) / 4;
    end else if (a12 >= 'h800 && a12 < 'h800 + CH * 8) begin
      kind = 2; ch = (a12 - 'h800) / 8; r = ((a12 - 'h800) % 8) / 4;
    end
  endtask

  // One clock: drive at negedge, check ready/valid before the edge, check bus/irq after.
  task automatic step();
    int pre_in [CH], pre_out [CH];
    int kind, ch, r;
    bit any_pend;
    logic [31:0] exp_rd;
    apply_drive();
    #1;
    any_pend = 0;
    for (int c = 0; c < CH; c++) begin
      pre_in[c]  = in_q[c].size();
      pre_out[c] = out_q[c].size();
      chk("in_ready", 32'(tb_in_ready[c]), 32'(pre_in[c] < DEPTH));
      chk("out_valid", 32'(tb_out_valid[c]), 32'(pre_out[c] > 0));
      if (pre_out[c] > 0) chk("out_data", tb_out_data[c], out_q[c][0]);
      if (m_irqen[c] && pre_in[c] >= ((m_thr[c] == 0) ? 1 : int'(m_thr[c]))) any_pend = 1;
    end
    for (int c = 0; c < CH; c++)
      if (d_outr[c] && pre_out[c] > 0) void'(out_q[c].pop_front());
    exp_rd = 0;
    decode(d_addr, kind, ch, r);
    if (d_req && kind == 1) begin
      case (r)
        0: if (!d_we) begin
             if (pre_in[ch] > 0) exp_rd = in_q[ch].pop_front();
             else m_unf[ch] = 1;
           end else if (d_be == 4'hF) begin
             if (pre_out[ch] < DEPTH || d_outr[ch]) begin
               out_q[ch].push_back(d_wdata); m_tout[ch]++;
             end else m_ovf[ch] = 1;
           end
        1: if (!d_we)
             exp_rd = {12'd0, m_ovf[ch], m_unf[ch], pre_out[ch] == DEPTH, pre_in[ch] == 0,
                       8'(pre_out[ch]), 8'(pre_in[ch])};
        2: if (!d_we) exp_rd = {31'd0, m_irqen[ch]};
           else begin
             m_irqen[ch] = d_wdata[0];
             if (d_wdata[1]) begin m_unf[ch] = 0; m_ovf[ch] = 0; end
           end
        default: if (!d_we) exp_rd = {24'd0, m_thr[ch]};
                 else m_thr[ch] = d_wdata[7:0];
      endcase
    end else if (d_req && kind == 2 && !d_we) begin
`ifdef DEV_TEST_FIFO_STATS_EN
      exp_rd = r ? m_tout[ch] : m_tin[ch];
`else
      exp_rd = 0;
`endif
    end
    for (int c = 0; c < CH; c++)
      if (d_inv[c] && pre_in[c] < DEPTH) begin
        in_q[c].push_back(d_indata[c]); m_tin[c]++;
      end
    if (!m_irq && any_pend) m_irq = 1;
    else if (m_irq && d_fin) m_irq = 0;
    @(negedge clk);
    chk("ack", 32'(bus_ack), 32'(d_req));
    if (d_req) chk("rdata", bus_rdata, exp_rd);
    chk("irq", 32'(int_req_o), 32'(m_irq));
    clr_drive();
  endtask

  task automatic bus_w(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    d_req = 1; d_we = 1; d_addr = a; d_wdata = wd; d_be = be; step();
  endtask

  task automatic bus_r(input logic [31:0] a);
    d_req = 1; d_we = 0; d_addr = a; step();
  endtask

  task automatic tb_push(input int c, input logic [31:0] v);
    d_inv[c] = 1'b1; d_indata[c] = v; step();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1; clr_drive(); apply_drive();
    repeat (2) @(negedge clk);
    rst = 0; model_clear();
  endtask

  int kind_sel, rch, rsel;

  initial begin
    rst = 1; clr_drive(); apply_drive(); model_clear();
    @(negedge clk);
    do_reset();
    chk("rst_ack", 32'(bus_ack), 0);
    chk("rst_rdata", bus_rdata, 0);
    chk("rst_irq", 32'(int_req_o), 0);
    chk("rst_in_ready", 32'(tb_in_ready), 32'((1 << CH) - 1));
    chk("rst_out_valid", 32'(tb_out_valid), 0);
    bus_r(32'h0C);
    chk("rst_thresh", bus_rdata, 32'd1);

    // FIFO order and underflow on ch0
    tb_push(0, 32'hA1); tb_push(0, 32'hA2); tb_push(0, 32'hA3);
    bus_r(32'h00); chk("r031_a1", bus_rdata, 32'hA1);
    bus_r(32'h00); chk("r031_a2", bus_rdata, 32'hA2);
    bus_r(32'h00); chk("r031_a3", bus_rdata, 32'hA3);
    bus_r(32'h00); chk("r031_empty", bus_rdata, 32'h0);
    bus_r(32'h04); chk("r031_unf", 32'(bus_rdata[18]), 1);
    bus_w(32'h08, 32'h2, 4'hF);
    bus_r(32'h04); chk("r031_clr", 32'(bus_rdata[19:18]), 0);

    // Output overflow on ch1 then drain in order
    for (int i = 0; i <= DEPTH; i++) bus_w(32'h10, 32'hC000_0000 + i, 4'hF);
    bus_r(32'h14);
    chk("r032_flags", bus_rdata & 32'h000A_0000, 32'h000A_0000);
    chk("r032_cnt", 32'(bus_rdata[15:8]), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      chk("r032_drain", tb_out_data[1], 32'hC000_0000 + i);
      d_outr[1] = 1'b1; step();
    end
    chk("r032_done", 32'(tb_out_valid[1]), 0);

    // Partial byte enables ignored, out-of-range addresses acked
    bus_w(32'h10, 32'h1234, 4'h3);
    bus_r(32'h14); chk("r034_cnt", 32'(bus_rdata[15:8]), 0);
    bus_w(32'h7F0, 32'hFFFF_FFFF, 4'hF);
    bus_r(32'h7F0); chk("r034_7f0", bus_rdata, 0);
    bus_r(32'h30); chk("r034_ch_oor", bus_rdata, 0);

    // Threshold interrupt
    do_reset();
    bus_w(32'h0C, 32'd3, 4'hF);
    bus_w(32'h08, 32'd1, 4'hF);
    tb_push(0, 32'h11); tb_push(0, 32'h22); idle(2);
    chk("r033_below", 32'(int_req_o), 0);
    tb_push(0, 32'h33); idle(1);
    chk("r033_on", 32'(int_req_o), 1);
    d_fin = 1; step();
    chk("r033_off", 32'(int_req_o), 0);
    step();
    chk("r033_again", 32'(int_req_o), 1);
    bus_w(32'h0C, 32'd0, 4'hF);
    bus_r(32'h0C); chk("r033_thr0", bus_rdata, 0);

    // Concurrent push and pop keep the count
    do_reset();
    tb_push(0, 32'h55); tb_push(0, 32'h66);
    d_inv[0] = 1; d_indata[0] = 32'h77; d_req = 1; d_addr = 32'h0; step();
    chk("r035_pop", bus_rdata, 32'h55);
    bus_r(32'h04); chk("r035_cnt", 32'(bus_rdata[7:0]), 2);

    // Stats counter
    do_reset();
    for (int i = 0; i < 5; i++) tb_push(0, 32'($urandom));
    bus_r(32'h800);
`ifdef DEV_TEST_FIFO_STATS_EN
    chk("r036_total_in", bus_rdata, 5);
`else
    chk("r036_total_in", bus_rdata, 0);
`endif

    // Random traffic
    do_reset();
    for (int n = 0; n < 800; n++) begin
      d_inv = CH'($urandom); d_outr = CH'($urandom);
      for (int c = 0; c < CH; c++) d_indata[c] = $urandom;
      d_fin = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) < 6) begin
        d_req = 1; d_we = $urandom_range(0, 1) == 1;
        kind_sel = $urandom_range(0, 9);
        rch = $urandom_range(0, 3);
        rsel = $urandom_range(0, 5);
        if (rsel > 3) rsel = 0;
        if (kind_sel < 8) d_addr = 32'(rch * 16 + rsel * 4) | ($urandom & 32'hFFFF_F000);
        else if (kind_sel == 8) d_addr = 32'h800 + 32'($urandom_range(0, 7) * 4);
        else d_addr = $urandom;
        d_be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        d_wdata = (rsel >= 2) ? 32'($urandom_range(0, 7)) : $urandom;
      end
      step();
    end

    // Reset in the middle of an access with the interrupt active
    bus_w(32'h08, 32'd1, 4'hF);
    tb_push(0, 32'h99); idle(2);
    chk("r026_pre_irq", 32'(int_req_o), 1);
    bus_req = 1; bus_we = 0; bus_addr = 32'h0; tb_in_valid = '1;
    #2 rst = 1;
    @(negedge clk);
    chk("r026_ack", 32'(bus_ack), 0);
    chk("r026_irq", 32'(int_req_o), 0);
    chk("r026_out_valid", 32'(tb_out_valid), 0);
    clr_drive(); apply_drive();
    rst = 0; model_clear();
    bus_r(32'h04); chk("r026_status", bus_rdata, 32'h0001_0000);
    bus_r(32'h14); chk("r026_status1", bus_rdata, 32'h0001_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dev_test_fifo.md
DEV_TEST_FIFO -- requirements
Module: dev_test_fifo

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent test channels, legal 1..4.
REQ-002 Parameter DEPTH, default 16: entries per FIFO, power of two, legal 4..64.
REQ-003 clk  in  1  single clock for all logic; bus side samples on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 bus_req, bus_we  in  1 each  access request and write strobe.
REQ-006 bus_addr  in  32  byte address; bits [11:0] decoded; bus_be  in  4  byte enables.
REQ-007 bus_wdata  in  32; bus_rdata  out  32; bus_ack  out  1.
REQ-008 int_fin_i  in  1  interrupt-serviced pulse; int_req_o  out  1  interrupt request.
REQ-009 tb_in_valid/tb_in_ready  in/out  CHANNELS  testbench-to-CPU push handshake; tb_in_data  in  CHANNELS*32.
REQ-010 tb_out_valid/tb_out_ready  out/in  CHANNELS  CPU-to-testbench pop handshake; tb_out_data  out  CHANNELS*32.

Function
REQ-011 Each channel SHALL own an input FIFO (testbench->CPU) and an output FIFO (CPU->testbench), each DEPTH x 32, count width $clog2(DEPTH)+1.
REQ-012 Channel c SHALL occupy addr[11:0] = c*16 .. c*16+15; register = addr[3:2]: 0 DATA, 1 STATUS, 2 CTRL, 3 THRESH.
REQ-013 bus_ack SHALL assert exactly one cycle after every bus_req cycle; bus_rdata SHALL be registered and valid in the ack cycle.
REQ-014 Read DATA: pop input FIFO, return head word; if empty return 0, no pop, set sticky UNDERFLOW.
REQ-015 Write DATA with bus_be==4'hF: push to output FIFO; if full drop word, set sticky OVERFLOW; any other bus_be SHALL be ignored.
REQ-016 STATUS read: [7:0] in_count, [15:8] out_count, [16] in_empty, [17] out_full, [18] UNDERFLOW, [19] OVERFLOW.
REQ-017 CTRL: bit0 IRQ_EN (R/W); writing 1 to bit1 clears UNDERFLOW and OVERFLOW (self-clearing, reads 0).
REQ-018 THRESH: [7:0] R/W, reset 1; value 0 SHALL be treated as 1.
REQ-019 tb_in_ready = input FIFO not full; push when valid&&ready; tb_out_valid = output FIFO not empty, tb_out_data = head, pop when valid&&ready.
REQ-020 Simultaneous push and pop on one FIFO SHALL both complete, count unchanged; on a full FIFO pop-and-push same cycle SHALL be accepted only for the output side if tb_out_ready and bus write coincide.
REQ-021 Pointers SHALL wrap modulo DEPTH; ordering strictly first-in first-out.
REQ-022 Addresses beyond CHANNELS*16 or >= 0x800: read 0, writes ignored, still acked.
REQ-023 Channel pending = IRQ_EN && in_count >= THRESH.
REQ-024 Interrupt FSM: IDLE -> REQ when any channel pending; REQ holds int_req_o=1; REQ -> IDLE on int_fin_i; IDLE re-evaluates next cycle (int_req_o low at least one cycle between requests).

Reset
REQ-025 On rst all FIFOs empty, flags 0, IRQ_EN 0, THRESH 1, FSM IDLE, bus_ack 0, bus_rdata 0, int_req_o 0.
REQ-026 Reset asserted mid-access SHALL abort it: no ack, no push/pop completes.

Configuration
REQ-027 Macro DEV_TEST_FIFO_STATS_EN defined: per-channel 32-bit wrapping counters TOTAL_IN (offset 0x800+c*8) and TOTAL_OUT (0x804+c*8) of accepted pushes, read-only, reset 0.
REQ-028 Macro undefined: counters absent, 0x800 region reads 0 per REQ-022.

Structure
REQ-029 Package dev_test_fifo_pkg SHALL hold register offset constants, STATUS bit positions, and the FSM state enum.
REQ-030 One sub-module dev_fifo (parameter DEPTH, 32-bit, push/pop/full/empty/count) SHALL be instantiated 2*CHANNELS times.

Verification
REQ-031 Push 3 words 0xA1,0xA2,0xA3 on ch0 tb side; CPU reads DATA x3 -> 0xA1,0xA2,0xA3; 4th read -> 0, STATUS[18]=1.
REQ-032 CPU writes DEPTH+1 words to ch1 DATA with tb_out_ready=0 -> out_full=1, OVERFLOW=1, tb drains exactly DEPTH words in order.
REQ-033 THRESH=3, IRQ_EN=1, push 2 words -> int_req_o=0; 3rd push -> int_req_o=1 within 2 cycles; int_fin_i pulse -> low, reasserts after one low cycle while still pending.
REQ-034 Write DATA with bus_be=4'h3 -> out_count unchanged; every req acked exactly one cycle later, including address 0x7F0.
REQ-035 Same-cycle tb push and CPU pop on ch0 with 2 entries -> in_count stays 2; rst mid-stream -> all counts 0, int_req_o 0.
REQ-036 With DEV_TEST_FIFO_STATS_EN: 5 pushes ch0 -> TOTAL_IN at 0x800 reads 5; without macro -> reads 0.
